// File: rtl/regfile_operand_fetch_pkg.sv
// rtl/regfile_operand_fetch_pkg.sv - shared widths, FSM encoding and zero-register constant
package regfile_pkg;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    VALID = 2'd2
  } state_t;
endpackage

// File: rtl/regfile_operand_fetch_if.sv
// rtl/regfile_operand_fetch_if.sv - instruction, register-file, writeback and operand signals
interface regfile_operand_fetch_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);
  import regfile_pkg::*;

  logic              InValid;
  logic              InReady;
  logic [ADDR_W-1:0] InSrc1;
  logic [ADDR_W-1:0] InSrc2;
  logic [ADDR_W-1:0] InDest;
  logic              InWritesDest;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic              WbValid;
  logic [ADDR_W-1:0] WbDest;
  logic [DATA_W-1:0] WbData;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutOperand1;
  logic [DATA_W-1:0] OutOperand2;
  logic [ADDR_W-1:0] OutDest;
  logic              OutWritesDest;

  modport master (
    input  InValid, InSrc1, InSrc2, InDest, InWritesDest, ReadData1, ReadData2,
           WbValid, WbDest, WbData, OutReady,
    output InReady, ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
           OutValid, OutOperand1, OutOperand2, OutDest, OutWritesDest
  );

  modport slave (
    output InValid, InSrc1, InSrc2, InDest, InWritesDest, ReadData1, ReadData2,
           WbValid, WbDest, WbData, OutReady,
    input  InReady, ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
           OutValid, OutOperand1, OutOperand2, OutDest, OutWritesDest
  );
endinterface

// File: rtl/regfile_operand_fetch_scoreboard.sv
// rtl/regfile_operand_fetch_scoreboard.sv - per-register pending bits with two source and one dest lookup
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_src1,
  input  logic [ADDR_W-1:0] i_src2,
  input  logic [ADDR_W-1:0] i_dest,
  output logic              o_pend_src1,
  output logic              o_pend_src2,
  output logic              o_pend_dest
);
  import regfile_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] r_pend;

  // set is applied after clear so it wins on a same-edge collision
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pend <= '0;
    end else begin
      if (i_clr) r_pend[i_clr_addr] <= 1'b0;
      if (i_set) r_pend[i_set_addr] <= 1'b1;
    end
  end

  assign o_pend_src1 = r_pend[i_src1];
  assign o_pend_src2 = r_pend[i_src2];
  assign o_pend_dest = r_pend[i_dest];
endmodule

// File: rtl/regfile_operand_fetch.sv
// rtl/regfile_operand_fetch.sv - operand fetch FSM, writeback stage, hazard stall; WB_BYPASS_EN adds bypass
module regfile_operand_fetch #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input logic                     Clk,
  input logic                     Rst_n,
  regfile_operand_fetch_if.master bus
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(ZERO_REG);

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_src1, r_src2, r_dest;
  logic              r_writes_dest;
  logic              r_out_valid, r_out_wd;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [ADDR_W-1:0] r_out_dest;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_pend_src1, w_pend_src2, w_pend_dest;
  logic              w_hz1, w_hz2, w_hz_dest, w_hazard;
  logic [DATA_W-1:0] w_op1, w_op2;
  logic              w_accept, w_capture, w_handoff, w_set, w_wb_load;

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i_set       (w_set),
    .i_set_addr  (r_out_dest),
    .i_clr       (r_reg_write),
    .i_clr_addr  (r_wr_addr),
    .i_src1      (r_src1),
    .i_src2      (r_src2),
    .i_dest      (r_dest),
    .o_pend_src1 (w_pend_src1),
    .o_pend_src2 (w_pend_src2),
    .o_pend_dest (w_pend_dest)
  );

`ifdef WB_BYPASS_EN
  logic w_wb1, w_wb2, w_rw1, w_rw2;
  // WbData is newer than WriteData, so it takes priority
  assign w_wb1 = bus.WbValid && (bus.WbDest == r_src1);
  assign w_wb2 = bus.WbValid && (bus.WbDest == r_src2);
  assign w_rw1 = r_reg_write && (r_wr_addr == r_src1);
  assign w_rw2 = r_reg_write && (r_wr_addr == r_src2);
  assign w_hz1 = (r_src1 != REG_ZERO) && w_pend_src1 && !(w_wb1 || w_rw1);
  assign w_hz2 = (r_src2 != REG_ZERO) && w_pend_src2 && !(w_wb2 || w_rw2);
  assign w_op1 = (r_src1 == REG_ZERO) ? '0 : w_wb1 ? bus.WbData : w_rw1 ? r_wr_data : bus.ReadData1;
  assign w_op2 = (r_src2 == REG_ZERO) ? '0 : w_wb2 ? bus.WbData : w_rw2 ? r_wr_data : bus.ReadData2;
`else
  assign w_hz1 = (r_src1 != REG_ZERO) && w_pend_src1;
  assign w_hz2 = (r_src2 != REG_ZERO) && w_pend_src2;
  assign w_op1 = (r_src1 == REG_ZERO) ? '0 : bus.ReadData1;
  assign w_op2 = (r_src2 == REG_ZERO) ? '0 : bus.ReadData2;
`endif

  assign w_hz_dest = r_writes_dest && (r_dest != REG_ZERO) && w_pend_dest;
  assign w_hazard  = w_hz1 || w_hz2 || w_hz_dest;
  assign w_accept  = (r_state == IDLE) && bus.InValid;
  assign w_capture = (r_state == CHECK) && !w_hazard;
  assign w_handoff = r_out_valid && bus.OutReady;
  assign w_set     = w_handoff && r_out_wd && (r_out_dest != REG_ZERO);
  assign w_wb_load = bus.WbValid && (bus.WbDest != REG_ZERO);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.InValid) w_next_state = CHECK;
      CHECK:   if (!w_hazard) w_next_state = VALID;
      VALID:   if (bus.OutReady) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= IDLE;
      r_src1        <= '0;
      r_src2        <= '0;
      r_dest        <= '0;
      r_writes_dest <= 1'b0;
      r_out_valid   <= 1'b0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_out_dest    <= '0;
      r_out_wd      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_src1        <= bus.InSrc1;
        r_src2        <= bus.InSrc2;
        r_dest        <= bus.InDest;
        r_writes_dest <= bus.InWritesDest;
      end
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_out_dest  <= r_dest;
        r_out_wd    <= r_writes_dest;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // one-cycle write strobe per writeback; address/data hold between writes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_reg_write <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_reg_write <= w_wb_load;
      if (w_wb_load) begin
        r_wr_addr <= bus.WbDest;
        r_wr_data <= bus.WbData;
      end
    end
  end

  assign bus.InReady       = (r_state == IDLE);
  assign bus.ReadRegister1 = r_src1;
  assign bus.ReadRegister2 = r_src2;
  assign bus.WriteRegister = r_wr_addr;
  assign bus.WriteData     = r_wr_data;
  assign bus.RegWrite      = r_reg_write;
  assign bus.OutValid      = r_out_valid;
  assign bus.OutOperand1   = r_op1;
  assign bus.OutOperand2   = r_op2;
  assign bus.OutDest       = r_out_dest;
  assign bus.OutWritesDest = r_out_wd;
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb/tb_regfile_operand_fetch.sv - directed and random checks of regfile_operand_fetch against an architectural model
module tb_regfile_operand_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_operand_fetch_if bus ();
  regfile_operand_fetch dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));

  // external register file; entry 0 holds garbage to prove the zero-register forcing
  logic [31:0] rf [4] = '{32'hBAD0BAD0, 32'h11111111, 32'h22222222, 32'h33333333};
  always @(posedge clk) if (bus.RegWrite) rf[bus.WriteRegister] <= bus.WriteData;
  assign bus.ReadData1 = rf[bus.ReadRegister1];
  assign bus.ReadData2 = rf[bus.ReadRegister2];

  logic [31:0] mdl [4];
  bit          pend [4];
  int          total = 0;
  int          bad = 0;

`ifdef WB_BYPASS_EN
  localparam int RAW_LAT = 1;
`else
  localparam int RAW_LAT = 3;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [1:0] s);
    return (s == 2'd0) ? 32'd0 : mdl[s];
  endfunction

  task automatic wb(input logic [1:0] d, input logic [31:0] v);
    bus.WbValid = 1'b1;
    bus.WbDest  = d;
    bus.WbData  = v;
    @(negedge clk);
    bus.WbValid = 1'b0;
    check("wb_regwrite", 32'(bus.RegWrite), 32'(d != 2'd0));
    if (d != 2'd0) begin
      check("wb_addr", 32'(bus.WriteRegister), 32'(d));
      check("wb_data", bus.WriteData, v);
      mdl[d]  = v;
      pend[d] = 1'b0;
    end
  endtask

  task automatic issue(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d, input logic w);
    int n = 0;
    while (!bus.InReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(bus.InReady), 32'd1);
    bus.InValid      = 1'b1;
    bus.InSrc1       = s1;
    bus.InSrc2       = s2;
    bus.InDest       = d;
    bus.InWritesDest = w;
    @(negedge clk);
    bus.InValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_out(input string tag, input int budget, output int n);
    n = 0;
    while (!bus.OutValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.OutValid), 32'd1);
  endtask

  task automatic check_out(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d, input logic w);
    check("out_op1", bus.OutOperand1, exp_op(s1));
    check("out_op2", bus.OutOperand2, exp_op(s2));
    check("out_dest", 32'(bus.OutDest), 32'(d));
    check("out_wd", 32'(bus.OutWritesDest), 32'(w));
  endtask

  task automatic accept(input logic [1:0] d, input logic w);
    bus.OutReady = 1'b1;
    @(negedge clk);
    bus.OutReady = 1'b0;
    check("acc_valid_low", 32'(bus.OutValid), 32'd0);
    check("acc_in_ready", 32'(bus.InReady), 32'd1);
    if (w && d != 2'd0) pend[d] = 1'b1;
  endtask

  task automatic run_instr(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d, input logic w);
    bit hz;
    int n;
    hz = (s1 != 2'd0 && pend[s1]) || (s2 != 2'd0 && pend[s2]) || (w && d != 2'd0 && pend[d]);
    issue(s1, s2, d, w);
    check("ri_first_valid", 32'(bus.OutValid), 32'(!hz));
    if (hz) begin
      if (s1 != 2'd0 && pend[s1]) wb(s1, $urandom);
      if (s2 != 2'd0 && pend[s2]) wb(s2, $urandom);
      if (w && d != 2'd0 && pend[d]) wb(d, $urandom);
      wait_out("ri_resolve", 20, n);
    end
    check_out(s1, s2, d, w);
    accept(d, w);
  endtask

  task automatic stall_cycles(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(tag, 32'(bus.OutValid), 32'd0);
      check("stall_in_ready", 32'(bus.InReady), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mdl = '{32'hBAD0BAD0, 32'h11111111, 32'h22222222, 32'h33333333};
    rst_n            = 1'b0;
    bus.InValid      = 1'b0;
    bus.InSrc1       = 2'd0;
    bus.InSrc2       = 2'd0;
    bus.InDest       = 2'd0;
    bus.InWritesDest = 1'b0;
    bus.WbValid      = 1'b0;
    bus.WbDest       = 2'd0;
    bus.WbData       = 32'd0;
    bus.OutReady     = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(bus.InReady), 32'd1);
    check("rst_out_valid", 32'(bus.OutValid), 32'd0);
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_rdaddr", 32'(bus.ReadRegister1), 32'd0);
    check("rst_wraddr", 32'(bus.WriteRegister), 32'd0);
    check("rst_wrdata", bus.WriteData, 32'd0);
    check("rst_op1", bus.OutOperand1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic read with zero-register forcing, result visible one edge after the accepting edge
    wb(2'd1, 32'hDEADBEEF);
    issue(2'd1, 2'd0, 2'd0, 1'b0);
    check("t1_valid", 32'(bus.OutValid), 32'd1);
    check("t1_op1", bus.OutOperand1, 32'hDEADBEEF);
    check("t1_op2", bus.OutOperand2, 32'd0);
    accept(2'd0, 1'b0);

    // RAW stall released by a writeback
    run_instr(2'd0, 2'd0, 2'd2, 1'b1);
    issue(2'd2, 2'd0, 2'd0, 1'b0);
    check("t2_stall", 32'(bus.OutValid), 32'd0);
    stall_cycles("t2_stall_hold", 3);
    wb(2'd2, 32'h5);
    n = 1;
    while (!bus.OutValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_latency", 32'(n), 32'(RAW_LAT));
    check("t2_op1", bus.OutOperand1, 32'h5);
    accept(2'd0, 1'b0);

    // backpressure: outputs and latched addresses hold while OutReady is low
    issue(2'd1, 2'd3, 2'd2, 1'b0);
    check("t3_valid", 32'(bus.OutValid), 32'd1);
    bus.InValid = 1'b1;
    bus.InSrc1  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(bus.OutValid), 32'd1);
      check("t3_hold_op1", bus.OutOperand1, exp_op(2'd1));
      check("t3_hold_op2", bus.OutOperand2, exp_op(2'd3));
      check("t3_hold_ready", 32'(bus.InReady), 32'd0);
      check("t3_hold_rdaddr", 32'(bus.ReadRegister1), 32'd1);
    end
    bus.InValid = 1'b0;
    accept(2'd2, 1'b0);

    // back-to-back writebacks, including an ignored write to register 0
    run_instr(2'd0, 2'd0, 2'd1, 1'b1);
    run_instr(2'd0, 2'd0, 2'd2, 1'b1);
    run_instr(2'd0, 2'd0, 2'd3, 1'b1);
    wb(2'd1, 32'd1);
    wb(2'd0, 32'hFFFF);
    wb(2'd2, 32'd2);
    wb(2'd3, 32'd3);
    run_instr(2'd1, 2'd2, 2'd0, 1'b0);
    run_instr(2'd3, 2'd0, 2'd0, 1'b0);

    // reset while stalled in CHECK
    run_instr(2'd0, 2'd0, 2'd1, 1'b1);
    issue(2'd1, 2'd0, 2'd0, 1'b0);
    check("t5_stall", 32'(bus.OutValid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5c_in_ready", 32'(bus.InReady), 32'd1);
    check("t5c_out_valid", 32'(bus.OutValid), 32'd0);
    check("t5c_regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend = '{default: 1'b0};

    // reset while holding in VALID with a register write in flight (the write is lost)
    issue(2'd2, 2'd0, 2'd3, 1'b1);
    check("t5v_valid", 32'(bus.OutValid), 32'd1);
    bus.WbValid = 1'b1;
    bus.WbDest  = 2'd2;
    bus.WbData  = 32'hCAFE0002;
    @(negedge clk);
    bus.WbValid = 1'b0;
    check("t5v_regwrite_hi", 32'(bus.RegWrite), 32'd1);
    check("t5v_valid_hold", 32'(bus.OutValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5v_out_valid", 32'(bus.OutValid), 32'd0);
    check("t5v_regwrite", 32'(bus.RegWrite), 32'd0);
    check("t5v_in_ready", 32'(bus.InReady), 32'd1);
    check("t5v_op1", bus.OutOperand1, 32'd0);
    check("t5v_rdaddr", 32'(bus.ReadRegister1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend = '{default: 1'b0};
    run_instr(2'd2, 2'd0, 2'd3, 1'b1);

    // WAW stall on register 3
    issue(2'd0, 2'd0, 2'd3, 1'b1);
    check("t6_stall", 32'(bus.OutValid), 32'd0);
    stall_cycles("t6_stall_hold", 3);
    wb(2'd3, 32'h3C3C3C3C);
    n = 1;
    while (!bus.OutValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_latency", 32'(n), 32'd3);
    check_out(2'd0, 2'd0, 2'd3, 1'b1);
    accept(2'd3, 1'b1);
    wb(2'd3, 32'h0BADF00D);

    // random instruction mix with interleaved writebacks
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) wb(2'($urandom_range(0, 3)), $urandom);
      run_instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
